quad_encoder_gen: RTL and testbench
===================================

QUAD_ENCODER_GEN -- requirements
Module: quad_encoder_gen

Interface
REQ-001 SHALL have clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have cmd_valid  input  1  move command present.
REQ-004 SHALL have cmd_ready  output  1  block able to accept a command; high exactly when state is IDLE, combinational from state.
REQ-005 SHALL have cmd_steps  input  16  number of quadrature steps (quarter-cycles) to emit, unsigned.
REQ-006 SHALL have cmd_dir  input  1  1 = forward (A leads B), 0 = reverse (B leads A).
REQ-007 SHALL have cmd_period  input  16  clk cycles per step, unsigned.
REQ-008 SHALL have abort  input  1  terminate a move in progress.
REQ-009 SHALL have A  output  1  quadrature channel A, registered.
REQ-010 SHALL have B  output  1  quadrature channel B, registered.
REQ-011 SHALL have position  output  16  signed step count, registered.
REQ-012 SHALL have steps_left  output  16  remaining steps of current move, registered.
REQ-013 SHALL have busy  output  1  high in RUN state.
REQ-014 SHALL have done  output  1  one-cycle pulse on normal move completion.

Function
REQ-015 SHALL implement states IDLE and RUN.
REQ-016 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both high, latching cmd_steps, cmd_dir and cmd_period (period 0 latched as 1).
REQ-017 SHALL, on acceptance with cmd_steps nonzero, enter RUN with step timer = 0 and steps_left = cmd_steps.
REQ-018 SHALL, on acceptance with cmd_steps = 0, stay in IDLE, pulse done the following cycle, and emit no edges.
REQ-019 SHALL, in RUN, increment the step timer each cycle and apply one step at the edge where timer = period-1, then reset timer to 0.
REQ-020 SHALL place the first step exactly period cycles after the acceptance edge; subsequent steps every period cycles.
REQ-021 SHALL sequence forward AB as 00->10->11->01->00 and reverse as 00->01->11->10->00, continuing from current AB (never reset between moves).
REQ-022 SHALL change exactly one of A/B per step (Gray sequence; no glitch states).
REQ-023 SHALL add +1 (forward) or -1 (reverse) to position per step, two's-complement, wrapping modulo 2^16 (0x7FFF+1 = 0x8000, 0x0000-1 = 0xFFFF).
REQ-024 SHALL decrement steps_left by 1 per step; on the edge applying the step that makes steps_left 0, SHALL return to IDLE and assert done for exactly the next cycle.
REQ-025 SHALL, when abort is high on an edge in RUN, return to IDLE, hold A/B/position, clear steps_left to 0, and not assert done; abort takes priority over a coincident step.
REQ-026 SHALL ignore abort in IDLE.
REQ-027 SHALL ignore cmd_valid while in RUN (cmd_ready low); a command held valid during the done cycle is accepted on that edge (cmd_ready already high).
REQ-028 SHALL ignore changes to cmd_* inputs after acceptance.

Reset
REQ-029 SHALL, when rst is high on an edge, force state IDLE, A=0, B=0, position=0, steps_left=0, step timer=0, done=0, regardless of state, including mid-move.
REQ-030 SHALL give rst priority over abort and command acceptance.
REQ-031 SHALL drive cmd_ready=1, busy=0 in the cycle after reset.

Verification
REQ-032 SHALL cover forward move: steps=8, dir=1, period=4 -> AB edges every 4 cycles, first 4 cycles after accept, sequence 10,11,01,00,10,11,01,00, position 0->8, done pulse once, 32 cycles busy.
REQ-033 SHALL cover reverse move from position 8: steps=3, dir=0, period=1 -> AB 01? no: from AB=00 sequence 01,11,10 on consecutive cycles, position 8->5.
REQ-034 SHALL cover abort: steps=100, period=10, abort after 25 cycles -> exactly 2 steps applied, position +2, steps_left=0, done never asserted, cmd_ready high next cycle.
REQ-035 SHALL cover boundaries: steps=0 -> done pulse, no AB change; period=0 -> behaves as period=1; position 0x7FFF + 1 forward step -> 0x8000.
REQ-036 SHALL cover reset mid-move: rst during step 5 of 10 -> AB=00, position=0, IDLE, no done; back-to-back command held valid across done -> second move starts with no idle gap beyond one cycle.
REQ-037 SHALL check every cycle that A and B never change on the same edge.

Source files
------------

// File: rtl/quad_encoder_gen.sv
// ---------------------------------------------------------------------------
// quad_encoder_gen
//
// Emits a quadrature (A/B) pulse train for a move command. A move is a
// number of quarter-cycle steps, a direction and a step period in clk cycles.
// Each step advances the Gray-coded AB pair by one position and updates a
// signed 16-bit position counter. AB and position carry over from one move
// to the next and are cleared only by reset.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous, active-high reset
//   cmd_valid   in   move command present
//   cmd_ready   out  high while IDLE (combinational from state)
//   cmd_steps   in   [15:0] number of quadrature steps to emit
//   cmd_dir     in   1 = forward (A leads B), 0 = reverse (B leads A)
//   cmd_period  in   [15:0] clk cycles per step (0 is treated as 1)
//   abort       in   stop the move in progress (ignored in IDLE)
//   A, B        out  quadrature channels, registered
//   position    out  [15:0] signed step count, wraps modulo 2^16
//   steps_left  out  [15:0] steps still to emit in the current move
//   busy        out  high in RUN
//   done        out  one-cycle pulse after a move completes normally
//   state_dbg   out  current FSM state (0 = IDLE, 1 = RUN)
//
// Command handshake: a command transfers on a rising edge where cmd_valid
// and cmd_ready are both high. cmd_ready depends only on state, never on
// cmd_valid. The cmd_* inputs are latched on that edge and not looked at
// again until the next transfer.
// ---------------------------------------------------------------------------
module quad_encoder_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_steps,
    input  logic        cmd_dir,
    input  logic [15:0] cmd_period,
    input  logic        abort,
    output logic        A,
    output logic        B,
    output logic [15:0] position,
    output logic [15:0] steps_left,
    output logic        busy,
    output logic        done,
    output logic [0:0]  state_dbg
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        a_q, a_d;
    logic        b_q, b_d;
    logic [15:0] position_q, position_d;
    logic [15:0] steps_left_q, steps_left_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] period_q, period_d;
    logic        dir_q, dir_d;
    logic        done_q, done_d;

    logic        step_due;
    logic [1:0]  ab_next;

    // Next AB code for one step. Forward walks 00->10->11->01->00, reverse
    // walks the same ring backwards; only one bit changes per step.
    always_comb begin
        ab_next = {a_q, b_q};
        if (dir_q) begin
            case ({a_q, b_q})
                2'b00:   ab_next = 2'b10;
                2'b10:   ab_next = 2'b11;
                2'b11:   ab_next = 2'b01;
                default: ab_next = 2'b00;
            endcase
        end else begin
            case ({a_q, b_q})
                2'b00:   ab_next = 2'b01;
                2'b01:   ab_next = 2'b11;
                2'b11:   ab_next = 2'b10;
                default: ab_next = 2'b00;
            endcase
        end
    end

    // period_q is never 0 (0 is latched as 1), so period_q - 1 cannot
    // underflow and a step is due once every period_q cycles.
    assign step_due = (timer_q == (period_q - 16'd1));

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        position_d   = position_q;
        steps_left_d = steps_left_q;
        timer_d      = timer_q;
        period_d     = period_q;
        dir_d        = dir_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    period_d = (cmd_period == 16'd0) ? 16'd1 : cmd_period;
                    dir_d    = cmd_dir;
                    timer_d  = 16'd0;
                    if (cmd_steps != 16'd0) begin
                        state_d      = S_RUN;
                        steps_left_d = cmd_steps;
                    end else begin
                        // Empty move: finishes at once, no edges.
                        done_d = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (abort) begin
                    // Abort wins over a step due on the same edge.
                    state_d      = S_IDLE;
                    steps_left_d = 16'd0;
                    timer_d      = 16'd0;
                end else if (step_due) begin
                    timer_d      = 16'd0;
                    a_d          = ab_next[1];
                    b_d          = ab_next[0];
                    position_d   = dir_q ? (position_q + 16'd1)
                                         : (position_q - 16'd1);
                    steps_left_d = steps_left_q - 16'd1;
                    if (steps_left_q == 16'd1) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            position_q   <= 16'd0;
            steps_left_q <= 16'd0;
            timer_q      <= 16'd0;
            period_q     <= 16'd1;
            dir_q        <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            position_q   <= position_d;
            steps_left_q <= steps_left_d;
            timer_q      <= timer_d;
            period_q     <= period_d;
            dir_q        <= dir_d;
            done_q       <= done_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q == S_RUN);
    assign A          = a_q;
    assign B          = b_q;
    assign position   = position_q;
    assign steps_left = steps_left_q;
    assign done       = done_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// ---------------------------------------------------------------------------
// tb_quad_encoder_gen
//
// Every expected step (edge cycle, AB code, position) is pushed to exp_q
// when a command is driven; the monitor pops an entry each time AB or
// position changes and compares. The monitor also checks that A and B never
// change on the same edge. A table of moves checks the end state of each
// move; hand-written sequences cover abort, reset mid-move, position wrap
// and back-to-back commands.
// ---------------------------------------------------------------------------
module tb_quad_encoder_gen;

  localparam int W = 50;  // {cycle[31:0], ab[1:0], position[15:0]}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_steps = 16'd0;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_period = 16'd0;
  logic        abort = 1'b0;
  logic        A, B;
  logic [15:0] position;
  logic [15:0] steps_left;
  logic        busy;
  logic        done;
  logic [0:0]  state_dbg;

  quad_encoder_gen dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_dir    (cmd_dir),
    .cmd_period (cmd_period),
    .abort      (abort),
    .A          (A),
    .B          (B),
    .position   (position),
    .steps_left (steps_left),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  int   cyc = 0;            // number of rising edges so far
  logic rst_at_edge = 1'b1; // rst as sampled by the latest rising edge
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  logic [1:0]  model_ab = 2'b00;
  logic [15:0] model_pos = 16'd0;

  task automatic check_val(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Gray ring position of an AB code: 00=0, 10=1, 11=2, 01=3.
  function automatic logic [1:0] ab_idx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] idx_ab(input logic [1:0] idx);
    logic [1:0] ring [4];
    ring[0] = 2'b00; ring[1] = 2'b10; ring[2] = 2'b11; ring[3] = 2'b01;
    return ring[idx];
  endfunction

  // Push the expected result of the first n steps of a move accepted at
  // rising edge acc.
  task automatic push_move(input int acc, input logic dir,
                           input logic [15:0] period, input int n);
    int eff;
    logic [31:0] c;
    eff = (period == 16'd0) ? 1 : int'(period);
    for (int k = 1; k <= n; k++) begin
      model_ab  = idx_ab(dir ? ab_idx(model_ab) + 2'd1 : ab_idx(model_ab) - 2'd1);
      model_pos = dir ? model_pos + 16'd1 : model_pos - 16'd1;
      c = 32'(acc + k * eff);
      exp_q.push_back({c, model_ab, model_pos});
    end
  endtask

  // ---------------- monitor ----------------
  logic [1:0]  prev_ab;
  logic [15:0] prev_pos;
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_at_edge) begin
      prev_ab  = {A, B};
      prev_pos = position;
    end else begin
      check_val("gray_single_change",
                32'((A !== prev_ab[1]) && (B !== prev_ab[0])), 32'd0);
      if ({A, B} !== prev_ab || position !== prev_pos) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_step: got AB=%b pos=0x%0h expected no change (cycle %0d)",
                   {A, B}, position, cyc);
        end else begin
          e = exp_q.pop_front();
          check_val("step_cycle", 32'(cyc), e[49:18]);
          check_val("step_ab", {30'd0, A, B}, {30'd0, e[17:16]});
          check_val("step_pos", {16'd0, position}, {16'd0, e[15:0]});
        end
      end
      prev_ab  = {A, B};
      prev_pos = position;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  // Drive one command; returns just after its acceptance edge with the
  // cmd_* inputs scrambled and cmd_valid low.
  task automatic issue(input logic [15:0] steps, input logic dir,
                       input logic [15:0] period, input int n_push,
                       output int acc);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_steps  = steps;
    cmd_dir    = dir;
    cmd_period = period;
    acc = cyc + 1;
    push_move(acc, dir, period, n_push);
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    cmd_steps  = 16'($urandom_range(0, 65535));
    cmd_dir    = 1'($urandom_range(0, 1));
    cmd_period = 16'($urandom_range(0, 65535));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    check_val("done_within_budget", 32'(seen), 32'd1);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] steps;
    logic        dir;
    logic [15:0] period;
    logic [15:0] exp_pos;
    logic [1:0]  exp_ab;
    int          exp_busy;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int acc, acc2, d0, b0;

    vecs[0] = '{16'd8, 1'b1, 16'd4, 16'd8,  2'b00, 32};  // forward 8 @ 4
    vecs[1] = '{16'd3, 1'b0, 16'd1, 16'd5,  2'b10, 3};   // reverse 3 @ 1
    vecs[2] = '{16'd0, 1'b1, 16'd5, 16'd5,  2'b10, 0};   // empty move
    vecs[3] = '{16'd5, 1'b1, 16'd0, 16'd10, 2'b11, 5};   // period 0 -> 1
    vecs[4] = '{16'd6, 1'b0, 16'd3, 16'd4,  2'b00, 18};  // reverse 6 @ 3

    // reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_val("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_ab", {30'd0, A, B}, 32'd0);
    check_val("reset_position", {16'd0, position}, 32'd0);
    check_val("reset_steps_left", {16'd0, steps_left}, 32'd0);
    check_val("reset_done", 32'(done), 32'd0);
    check_val("reset_state", 32'(state_dbg), 32'd0);

    // table-driven moves
    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt;
      b0 = busy_cnt;
      issue(vecs[i].steps, vecs[i].dir, vecs[i].period, int'(vecs[i].steps), acc);
      wait_done(5000);
      check_val($sformatf("vec%0d_position", i), {16'd0, position}, {16'd0, vecs[i].exp_pos});
      check_val($sformatf("vec%0d_ab", i), {30'd0, A, B}, {30'd0, vecs[i].exp_ab});
      check_val($sformatf("vec%0d_steps_left", i), {16'd0, steps_left}, 32'd0);
      check_val($sformatf("vec%0d_done_count", i), 32'(done_cnt - d0), 32'd1);
      check_val($sformatf("vec%0d_busy_cycles", i), 32'(busy_cnt - b0), 32'(vecs[i].exp_busy));
      check_val($sformatf("vec%0d_queue_empty", i), 32'(exp_q.size()), 32'd0);
    end

    // abort after 25 cycles of a 100-step, period-10 move; a different
    // command held valid during RUN must be ignored
    d0 = done_cnt;
    issue(16'd100, 1'b1, 16'd10, 2, acc);
    cmd_valid = 1'b1; cmd_steps = 16'd1; cmd_period = 16'd1; cmd_dir = 1'b0;
    @(negedge clk);
    check_val("run_cmd_ready_low", 32'(cmd_ready), 32'd0);
    wait_until(acc + 10);
    cmd_valid = 1'b0;
    wait_until(acc + 24);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_state", 32'(state_dbg), 32'd0);
    check_val("abort_steps_left", {16'd0, steps_left}, 32'd0);
    check_val("abort_position", {16'd0, position}, 32'd6);
    check_val("abort_ab", {30'd0, A, B}, 32'b11);
    check_val("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check_val("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // abort in IDLE is ignored
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    check_val("idle_abort_ready", 32'(cmd_ready), 32'd1);
    check_val("idle_abort_position", {16'd0, position}, 32'd6);

    // reset during step 5 of 10
    d0 = done_cnt;
    issue(16'd10, 1'b1, 16'd4, 4, acc);
    wait_until(acc + 17);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("midreset_queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    model_ab = 2'b00;
    model_pos = 16'd0;
    check_val("midreset_ab", {30'd0, A, B}, 32'd0);
    check_val("midreset_position", {16'd0, position}, 32'd0);
    check_val("midreset_ready", 32'(cmd_ready), 32'd1);
    check_val("midreset_busy", 32'(busy), 32'd0);
    check_val("midreset_steps_left", {16'd0, steps_left}, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check_val("midreset_no_done", 32'(done_cnt - d0), 32'd0);

    // wrap below zero and back
    issue(16'd1, 1'b0, 16'd1, 1, acc);
    wait_done(100);
    check_val("wrap_down_position", {16'd0, position}, 32'hFFFF);
    check_val("wrap_down_ab", {30'd0, A, B}, 32'b01);
    issue(16'd1, 1'b1, 16'd1, 1, acc);
    wait_done(100);
    check_val("wrap_up_zero", {16'd0, position}, 32'd0);

    // climb to 0x7FFF, then one forward step to 0x8000
    issue(16'd32767, 1'b1, 16'd1, 32767, acc);
    wait_done(40000);
    check_val("max_position", {16'd0, position}, 32'h7FFF);
    check_val("max_ab", {30'd0, A, B}, 32'b01);
    issue(16'd1, 1'b1, 16'd1, 1, acc);
    wait_done(100);
    check_val("signed_wrap_position", {16'd0, position}, 32'h8000);
    check_val("signed_wrap_ab", {30'd0, A, B}, 32'b00);

    // back-to-back: second command held valid through the done cycle
    d0 = done_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_steps = 16'd2; cmd_dir = 1'b1; cmd_period = 16'd2;
    acc = cyc + 1;
    push_move(acc, 1'b1, 16'd2, 2);
    @(posedge clk);
    #1;
    cmd_steps = 16'd3; cmd_dir = 1'b0; cmd_period = 16'd1;
    acc2 = acc + 2 * 2 + 1;
    push_move(acc2, 1'b0, 16'd1, 3);
    wait_until(acc2);
    cmd_valid = 1'b0;
    check_val("b2b_second_busy", 32'(busy), 32'd1);
    wait_until(acc2 + 4);
    #1;
    check_val("b2b_done_count", 32'(done_cnt - d0), 32'd2);
    check_val("b2b_position", {16'd0, position}, 32'h7FFF);
    check_val("b2b_ab", {30'd0, A, B}, 32'b01);
    check_val("b2b_ready", 32'(cmd_ready), 32'd1);

    repeat (3) @(negedge clk);
    check_val("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
